// File: rtl/d_sram_bridge.sv
// d_sram_bridge: data-side bridge from the core's M-stage data port to an
// SRAM-like bus with addr_ok/data_ok handshakes. Each load/store becomes one
// split request/response transaction. The pipeline is stalled until the
// response arrives, and read data is held until the pipeline moves on.
module d_sram_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_wen,
    input  logic [1:0]  cpu_size,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_except,
    input  logic        other_stall,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_reg;

    // A new access launches only from IDLE, and only if M is not being flushed.
    logic start;
    assign start = cpu_en & ~cpu_except;

    // Transaction FSM. Bus request fields are latched on launch and stay put
    // until the next launch. DONE holds the read data while the pipeline is
    // frozen by someone else, and it never re-launches the same instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= S_IDLE;
            data_wr    <= 1'b0;
            data_size  <= 2'd0;
            data_addr  <= 32'd0;
            data_wdata <= 32'd0;
            cpu_rdata  <= 32'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        data_wr    <= |cpu_wen;
                        data_size  <= cpu_size;
                        data_addr  <= cpu_addr;
                        data_wdata <= cpu_wdata;
                        state_reg  <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Once raised the request is held until accepted, even if
                    // an exception shows up meanwhile.
                    if (data_addr_ok) begin
                        state_reg <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (data_data_ok) begin
                        if (!data_wr) begin
                            cpu_rdata <= data_rdata;
                        end
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!other_stall) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Stall covers the launch decision cycle plus the whole bus round trip.
    // The DONE cycle is deliberately left unstalled so the pipeline can advance.
    always_comb begin
        cpu_stall = rst & (((state_reg == S_IDLE) & start) |
                           (state_reg == S_REQ) |
                           (state_reg == S_WAIT));
    end

    // Request is a pure decode of the registered state, so it is glitch-free.
    always_comb begin
        data_req = rst & (state_reg == S_REQ);
    end

endmodule

// File: tb/tb_d_sram_bridge.sv
// tb_d_sram_bridge: directed bench for d_sram_bridge. Inputs are driven on the
// falling edge, and outputs are sampled on the falling edge (or just after it).
// The bench plays the bus side with programmable addr_ok/data_ok delays.
module tb_d_sram_bridge;

    logic        clk;
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_except;
    logic        other_stall;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int n_cmp;
    int n_bad;

    d_sram_bridge dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_en       (cpu_en),
        .cpu_wen      (cpu_wen),
        .cpu_size     (cpu_size),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_except   (cpu_except),
        .other_stall  (other_stall),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete access. The bus accepts after a_dly REQ cycles and responds
    // d_dly cycles after the first WAIT cycle. hold = other_stall cycles in DONE.
    // If exc_req is set, cpu_except is raised once the request is visible.
    task automatic do_access(input string name,
                             input logic [3:0]  wen,
                             input logic [1:0]  size,
                             input logic [31:0] addr,
                             input logic [31:0] wdata,
                             input logic [31:0] bus_rdata,
                             input logic [31:0] exp_rdata,
                             input int a_dly, input int d_dly,
                             input int hold, input bit exc_req);
        int  stall_n;
        int  req_n;
        int  wcnt;
        int  cyc;
        bit  in_wait;
        bit  done;
        stall_n = 0; req_n = 0; wcnt = 0; cyc = 0; in_wait = 0; done = 0;
        @(negedge clk);
        rst = 1'b1;
        cpu_en = 1'b1; cpu_wen = wen; cpu_size = size; cpu_addr = addr;
        cpu_wdata = wdata; cpu_except = 1'b0; other_stall = 1'b0;
        #1;
        while (!done && cyc < 40) begin
            if (cpu_stall) stall_n++;
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            data_rdata   = 32'hBAD0_BAD0;
            if (data_req) begin
                req_n++;
                if (exc_req) cpu_except = 1'b1;
                data_addr_ok = ((req_n - 1) == a_dly);
            end
            if (in_wait) begin
                wcnt++;
                if ((wcnt - 1) == d_dly) begin
                    data_data_ok = 1'b1;
                    data_rdata   = bus_rdata;
                end
            end
            if (data_req || in_wait) begin
                chk({name, ".addr"},  data_addr,  addr);
                chk({name, ".wr"},    {31'd0, data_wr}, {31'd0, |wen});
                chk({name, ".size"},  {30'd0, data_size}, {30'd0, size});
                chk({name, ".wdata"}, data_wdata, wdata);
            end
            @(posedge clk);
            if (data_addr_ok) in_wait = 1'b1;
            if (data_data_ok) begin
                in_wait = 1'b0;
                done    = 1'b1;
            end
            cyc++;
            @(negedge clk);
            #1;
        end
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'hBAD0_BAD0;
        chk({name, ".completed"}, {31'd0, done}, 32'd1);
        chk({name, ".stall_cycles"}, stall_n, 3 + a_dly + d_dly);
        chk({name, ".req_cycles"}, req_n, a_dly + 1);
        // Now in DONE: hold for `hold` cycles, then let the pipeline advance.
        for (int h = 0; h <= hold; h++) begin
            other_stall = (h < hold);
            cpu_except  = 1'b0;
            #1;
            chk({name, ".done_stall"}, {31'd0, cpu_stall}, 32'd0);
            chk({name, ".done_req"},   {31'd0, data_req},  32'd0);
            chk({name, ".rdata"},      cpu_rdata, exp_rdata);
            @(posedge clk);
            if (h == hold) begin
                #1;
                cpu_en  = 1'b0;
                cpu_wen = 4'd0;
            end
            @(negedge clk);
        end
        other_stall = 1'b0;
        #1;
        chk({name, ".idle_stall"}, {31'd0, cpu_stall}, 32'd0);
        chk({name, ".idle_req"},   {31'd0, data_req},  32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({name, ".no_reissue"}, {31'd0, data_req}, 32'd0);
        chk({name, ".rdata_after"}, cpu_rdata, exp_rdata);
        $display("access %s done: stall=%0d req=%0d rdata=%h", name, stall_n, req_n, cpu_rdata);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b0; cpu_en = 1'b0; cpu_wen = 4'd0; cpu_size = 2'd0;
        cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_except = 1'b0; other_stall = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst.req",   {31'd0, data_req},  32'd0);
        chk("rst.rdata", cpu_rdata, 32'd0);
        chk("rst.addr",  data_addr, 32'd0);
        rst = 1'b1;
        @(posedge clk);

        // Load word, zero-wait bus
        do_access("lw", 4'b0000, 2'd2, 32'h0000_1004, 32'h0000_0000,
                  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 0, 1'b0);
        // Store byte: read data register must not change
        do_access("sb", 4'b0100, 2'd0, 32'h0000_1006, 32'h00AB_0000,
                  32'h1234_5678, 32'hDEAD_BEEF, 0, 0, 0, 1'b0);
        // Slow bus: addr_ok after 2 extra cycles, data_ok after 3 extra
        do_access("lh_slow", 4'b0000, 2'd1, 32'h0000_2002, 32'h0000_0000,
                  32'h0000_BEEF, 32'h0000_BEEF, 2, 3, 0, 1'b0);
        // Pipeline held elsewhere for 4 cycles after completion
        do_access("lw_hold", 4'b0000, 2'd2, 32'h0000_3000, 32'h0000_0000,
                  32'hCAFE_F00D, 32'hCAFE_F00D, 1, 0, 4, 1'b0);

        // Exception in IDLE suppresses the access
        @(negedge clk);
        cpu_en = 1'b1; cpu_except = 1'b1; cpu_wen = 4'd0; cpu_addr = 32'h0000_9000;
        #1;
        chk("exc_idle.stall", {31'd0, cpu_stall}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("exc_idle.req",   {31'd0, data_req},  32'd0);
        chk("exc_idle.stall2", {31'd0, cpu_stall}, 32'd0);
        $display("access exc_idle done: req=%0d stall=%0d", data_req, cpu_stall);
        cpu_en = 1'b0; cpu_except = 1'b0;
        @(posedge clk);

        // Exception raised during REQ: transaction still completes
        do_access("sw_exc", 4'b1111, 2'd2, 32'h0000_4000, 32'h55AA_55AA,
                  32'h7777_7777, 32'hCAFE_F00D, 1, 0, 0, 1'b1);

        // Reset while in WAIT abandons the transaction
        @(negedge clk);
        cpu_en = 1'b1; cpu_wen = 4'd0; cpu_size = 2'd2; cpu_addr = 32'h0000_2000;
        cpu_wdata = 32'h0000_0000;
        @(posedge clk);
        @(negedge clk);
        chk("rst_wait.req", {31'd0, data_req}, 32'd1);
        data_addr_ok = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data_addr_ok = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_wait.stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_wait.req0",  {31'd0, data_req},  32'd0);
        chk("rst_wait.addr",  data_addr, 32'd0);
        chk("rst_wait.wr",    {31'd0, data_wr}, 32'd0);
        chk("rst_wait.size",  {30'd0, data_size}, 32'd0);
        chk("rst_wait.wdata", data_wdata, 32'd0);
        chk("rst_wait.rdata", cpu_rdata, 32'd0);
        $display("access rst_wait done: addr=%h rdata=%h", data_addr, cpu_rdata);
        @(posedge clk);

        // Fresh request after reset release
        do_access("lw_after_rst", 4'b0000, 2'd2, 32'h0000_5008, 32'h0000_0000,
                  32'h600D_F00D, 32'h600D_F00D, 0, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
